// File: rtl/combat_resolver.sv
// -----------------------------------------------------------------------------
// combat_resolver
// Resolves punches and kicks between the left and right fighters once per
// video frame. It applies reach, block and post-hit cooldown rules and tracks
// each fighter's health.
//
// Ports:
//   clk_25MHz        in   pixel clock, sole clock
//   Reset            in   synchronous, active-low reset
//   vsync            in   VGA vsync; its rising edge is the frame tick
//   fighting         in   high while the fight screen is shown
//   edgeL_R          in   [9:0] right edge X of the left fighter
//   edgeR_L          in   [9:0] left edge X of the right fighter
//   punchL/kickL/blockL, punchR/kickR/blockR   in   action levels
//   healthL/healthR  out  [7:0] current health (registered)
//   deathL/deathR    out  fighter is at 0 health (registered)
//   hitL/hitR        out  one-cycle pulse when that fighter takes damage
// -----------------------------------------------------------------------------
module combat_resolver #(
    parameter logic [7:0] MAX_HEALTH      = 8'd100,
    parameter logic [7:0] PUNCH_DMG       = 8'd5,
    parameter logic [7:0] KICK_DMG        = 8'd10,
    parameter int         BLOCK_SHIFT     = 2,
    parameter logic [9:0] PUNCH_REACH     = 10'd16,
    parameter logic [9:0] KICK_REACH      = 10'd24,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd20
) (
    input  logic       clk_25MHz,
    input  logic       Reset,
    input  logic       vsync,
    input  logic       fighting,
    input  logic [9:0] edgeL_R,
    input  logic [9:0] edgeR_L,
    input  logic       punchL,
    input  logic       kickL,
    input  logic       blockL,
    input  logic       punchR,
    input  logic       kickR,
    input  logic       blockR,
    output logic [7:0] healthL,
    output logic [7:0] healthR,
    output logic       deathL,
    output logic       deathR,
    output logic       hitL,
    output logic       hitR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIGHT = 2'd1,
        KO    = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic       vsync_q_r, fighting_q_r;
    logic [7:0] cooldown_l_r, cooldown_r_r;
    logic [7:0] cooldown_l_s, cooldown_r_s;
    logic [7:0] health_l_s, health_r_s;
    logic       death_l_s, death_r_s, hit_l_s, hit_r_s;

    logic       frame_tick_s, fight_start_s;
    logic [9:0] gap_s;
    logic       kick_l_ok_s, punch_l_ok_s, kick_r_ok_s, punch_r_ok_s;
    logic       land_l_s, land_r_s;
    logic [7:0] dmg_to_r_s, dmg_to_l_s;

    // Health minus damage, clamped at zero so a low fighter never wraps to 255.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        if (a > b) begin
            res = a - b;
        end else begin
            res = 8'd0;
        end
        return res;
    endfunction

    assign frame_tick_s  = vsync & ~vsync_q_r;
    assign fight_start_s = fighting & ~fighting_q_r;

    // Overlapping fighters count as touching (gap 0).
    assign gap_s = (edgeR_L >= edgeL_R) ? (edgeR_L - edgeL_R) : 10'd0;

    assign kick_l_ok_s  = kickL  && (gap_s <= KICK_REACH);
    assign punch_l_ok_s = punchL && (gap_s <= PUNCH_REACH);
    assign kick_r_ok_s  = kickR  && (gap_s <= KICK_REACH);
    assign punch_r_ok_s = punchR && (gap_s <= PUNCH_REACH);

    // An attacker can only land while its cooldown is clear and it is not blocking.
    assign land_l_s = (cooldown_l_r == 8'd0) && !blockL && (kick_l_ok_s || punch_l_ok_s);
    assign land_r_s = (cooldown_r_r == 8'd0) && !blockR && (kick_r_ok_s || punch_r_ok_s);

    // Damage dealt by each side; kick wins over punch when it is in reach.
    always_comb begin
        dmg_to_r_s = 8'd0;
        dmg_to_l_s = 8'd0;
        if (land_l_s) begin
            dmg_to_r_s = kick_l_ok_s ? KICK_DMG : PUNCH_DMG;
            if (blockR) begin
                dmg_to_r_s = dmg_to_r_s >> BLOCK_SHIFT;
            end else begin
                dmg_to_r_s = dmg_to_r_s;
            end
        end else begin
            dmg_to_r_s = 8'd0;
        end
        if (land_r_s) begin
            dmg_to_l_s = kick_r_ok_s ? KICK_DMG : PUNCH_DMG;
            if (blockL) begin
                dmg_to_l_s = dmg_to_l_s >> BLOCK_SHIFT;
            end else begin
                dmg_to_l_s = dmg_to_l_s;
            end
        end else begin
            dmg_to_l_s = 8'd0;
        end
    end

    // Next-state and next-value logic for the round FSM.
    always_comb begin
        state_s      = state_r;
        health_l_s   = healthL;
        health_r_s   = healthR;
        death_l_s    = deathL;
        death_r_s    = deathR;
        hit_l_s      = 1'b0;
        hit_r_s      = 1'b0;
        cooldown_l_s = cooldown_l_r;
        cooldown_r_s = cooldown_r_r;
        case (state_r)
            IDLE: begin
                health_l_s   = MAX_HEALTH;
                health_r_s   = MAX_HEALTH;
                death_l_s    = 1'b0;
                death_r_s    = 1'b0;
                cooldown_l_s = 8'd0;
                cooldown_r_s = 8'd0;
                if (fight_start_s) begin
                    state_s = FIGHT;
                end else begin
                    state_s = IDLE;
                end
            end
            FIGHT: begin
                if (!fighting) begin
                    state_s      = IDLE;
                    health_l_s   = MAX_HEALTH;
                    health_r_s   = MAX_HEALTH;
                    death_l_s    = 1'b0;
                    death_r_s    = 1'b0;
                    cooldown_l_s = 8'd0;
                    cooldown_r_s = 8'd0;
                end else if (frame_tick_s) begin
                    // Both sides resolve from pre-tick health, so a double KO is possible.
                    if (cooldown_l_r != 8'd0) begin
                        cooldown_l_s = cooldown_l_r - 8'd1;
                    end else if (land_l_s) begin
                        cooldown_l_s = COOLDOWN_FRAMES;
                    end else begin
                        cooldown_l_s = 8'd0;
                    end
                    if (cooldown_r_r != 8'd0) begin
                        cooldown_r_s = cooldown_r_r - 8'd1;
                    end else if (land_r_s) begin
                        cooldown_r_s = COOLDOWN_FRAMES;
                    end else begin
                        cooldown_r_s = 8'd0;
                    end
                    health_r_s = sat_sub(healthR, dmg_to_r_s);
                    health_l_s = sat_sub(healthL, dmg_to_l_s);
                    hit_r_s    = (dmg_to_r_s != 8'd0);
                    hit_l_s    = (dmg_to_l_s != 8'd0);
                    death_r_s  = (health_r_s == 8'd0);
                    death_l_s  = (health_l_s == 8'd0);
                    if (death_l_s || death_r_s) begin
                        state_s = KO;
                    end else begin
                        state_s = FIGHT;
                    end
                end else begin
                    state_s = FIGHT;
                end
            end
            KO: begin
                // Outputs stay frozen so the ending screen keeps seeing the death flags.
                if (fight_start_s) begin
                    state_s      = FIGHT;
                    health_l_s   = MAX_HEALTH;
                    health_r_s   = MAX_HEALTH;
                    death_l_s    = 1'b0;
                    death_r_s    = 1'b0;
                    cooldown_l_s = 8'd0;
                    cooldown_r_s = 8'd0;
                end else begin
                    state_s = KO;
                end
            end
            default: begin
                state_s      = IDLE;
                health_l_s   = MAX_HEALTH;
                health_r_s   = MAX_HEALTH;
                death_l_s    = 1'b0;
                death_r_s    = 1'b0;
                cooldown_l_s = 8'd0;
                cooldown_r_s = 8'd0;
            end
        endcase
    end

    // State, edge-detect history, cooldowns and registered outputs.
    always_ff @(posedge clk_25MHz) begin
        if (!Reset) begin
            state_r      <= IDLE;
            vsync_q_r    <= 1'b0;
            fighting_q_r <= 1'b0;
            cooldown_l_r <= 8'd0;
            cooldown_r_r <= 8'd0;
            healthL      <= MAX_HEALTH;
            healthR      <= MAX_HEALTH;
            deathL       <= 1'b0;
            deathR       <= 1'b0;
            hitL         <= 1'b0;
            hitR         <= 1'b0;
        end else begin
            state_r      <= state_s;
            vsync_q_r    <= vsync;
            fighting_q_r <= fighting;
            cooldown_l_r <= cooldown_l_s;
            cooldown_r_r <= cooldown_r_s;
            healthL      <= health_l_s;
            healthR      <= health_r_s;
            deathL       <= death_l_s;
            deathR       <= death_r_s;
            hitL         <= hit_l_s;
            hitR         <= hit_r_s;
        end
    end

endmodule

// File: tb/tb_combat_resolver.sv
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic       fighting = 1'b0;
    logic [9:0] edge_lr = 10'd0;
    logic [9:0] edge_rl = 10'd0;
    logic       p_l = 1'b0, k_l = 1'b0, b_l = 1'b0;
    logic       p_r = 1'b0, k_r = 1'b0, b_r = 1'b0;

    logic [7:0] a_hl, a_hr, b_hl, b_hr, c_hl, c_hr;
    logic       a_dl, a_dr, a_xl, a_xr;
    logic       b_dl, b_dr, b_xl, b_xr;
    logic       c_dl, c_dr, c_xl, c_xr;

    int checks = 0;
    int fails  = 0;
    int cnt_ar = 0;

    always #20 clk = ~clk;

    combat_resolver dut_a (
        .clk_25MHz(clk), .Reset(rst), .vsync(vsync), .fighting(fighting),
        .edgeL_R(edge_lr), .edgeR_L(edge_rl),
        .punchL(p_l), .kickL(k_l), .blockL(b_l), .punchR(p_r), .kickR(k_r), .blockR(b_r),
        .healthL(a_hl), .healthR(a_hr), .deathL(a_dl), .deathR(a_dr), .hitL(a_xl), .hitR(a_xr));

    combat_resolver #(.MAX_HEALTH(8'd12)) dut_b (
        .clk_25MHz(clk), .Reset(rst), .vsync(vsync), .fighting(fighting),
        .edgeL_R(edge_lr), .edgeR_L(edge_rl),
        .punchL(p_l), .kickL(k_l), .blockL(b_l), .punchR(p_r), .kickR(k_r), .blockR(b_r),
        .healthL(b_hl), .healthR(b_hr), .deathL(b_dl), .deathR(b_dr), .hitL(b_xl), .hitR(b_xr));

    combat_resolver #(.MAX_HEALTH(8'd10)) dut_c (
        .clk_25MHz(clk), .Reset(rst), .vsync(vsync), .fighting(fighting),
        .edgeL_R(edge_lr), .edgeR_L(edge_rl),
        .punchL(p_l), .kickL(k_l), .blockL(b_l), .punchR(p_r), .kickR(k_r), .blockR(b_r),
        .healthL(c_hl), .healthR(c_hr), .deathL(c_dl), .deathR(c_dr), .hitL(c_xl), .hitR(c_xr));

    // Counts cycles in which dut_a's hitR is high.
    always @(negedge clk) begin
        if (a_xr) cnt_ar = cnt_ar + 1;
    end

    // One frame: a posedge with vsync low, then a posedge with vsync high.
    // Returns at the negedge right after the tick has been resolved.
    task automatic frame();
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic start_fight();
        {p_l, k_l, b_l, p_r, k_r, b_r} = 6'b000000;
        fighting = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fighting = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_hl !== 8'd100 || a_hr !== 8'd100) begin
            fails++; $display("FAIL reset_health got %0d/%0d want 100/100", a_hl, a_hr);
        end
        checks++;
        if ({a_dl, a_dr, a_xl, a_xr} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {a_dl, a_dr, a_xl, a_xr});
        end
        rst = 1'b1;
        edge_lr = 10'd100; edge_rl = 10'd110; // gap 10
        p_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd100 || a_xr !== 1'b0) begin
            fails++; $display("FAIL idle_ignores_tick got %0d hit %b want 100 hit 0", a_hr, a_xr);
        end
    endtask

    task automatic test_punch_cooldown();
        int start_cnt;
        fighting = 1'b1;
        @(negedge clk);
        start_cnt = cnt_ar;
        for (int i = 0; i < 60; i++) begin
            frame();
            if (i == 0) begin
                checks++;
                if (a_hr !== 8'd95) begin fails++; $display("FAIL punch_t0 got %0d want 95", a_hr); end
            end
            if (i == 20) begin
                checks++;
                if (a_hr !== 8'd95) begin fails++; $display("FAIL punch_t20 got %0d want 95", a_hr); end
            end
            if (i == 21) begin
                checks++;
                if (a_hr !== 8'd90) begin fails++; $display("FAIL punch_t21 got %0d want 90", a_hr); end
            end
            if (i == 42) begin
                checks++;
                if (a_hr !== 8'd85) begin fails++; $display("FAIL punch_t42 got %0d want 85", a_hr); end
            end
        end
        checks++;
        if (a_hr !== 8'd85 || a_hl !== 8'd100) begin
            fails++; $display("FAIL punch_end got %0d/%0d want 100/85", a_hl, a_hr);
        end
        checks++;
        if (cnt_ar - start_cnt !== 3) begin
            fails++; $display("FAIL hit_pulse_cycles got %0d want 3", cnt_ar - start_cnt);
        end
    endtask

    task automatic test_reach();
        fighting = 1'b0;
        @(negedge clk);
        checks++;
        if (a_hr !== 8'd100) begin fails++; $display("FAIL fight_drop_reload got %0d want 100", a_hr); end
        start_fight();
        edge_lr = 10'd100; edge_rl = 10'd120; // gap 20
        p_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd100) begin fails++; $display("FAIL punch_gap20 got %0d want 100", a_hr); end
        p_l = 1'b0; k_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd90) begin fails++; $display("FAIL kick_gap20 got %0d want 90", a_hr); end
        start_fight();
        edge_rl = 10'd130; // gap 30
        k_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd100) begin fails++; $display("FAIL kick_gap30 got %0d want 100", a_hr); end
        edge_rl = 10'd114; // gap 14, both held: kick wins
        p_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd90) begin fails++; $display("FAIL kick_priority got %0d want 90", a_hr); end
    endtask

    task automatic test_block();
        start_fight();
        edge_lr = 10'd100; edge_rl = 10'd100; // gap 0
        b_r = 1'b1; k_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd98 || a_xr !== 1'b1) begin
            fails++; $display("FAIL blocked_kick got %0d hit %b want 98 hit 1", a_hr, a_xr);
        end
        @(negedge clk);
        checks++;
        if (a_xr !== 1'b0) begin fails++; $display("FAIL hit_one_cycle got %b want 0", a_xr); end
        start_fight();
        b_r = 1'b1; b_l = 1'b1; k_l = 1'b1;
        frame();
        checks++;
        if (a_hr !== 8'd100 || a_xr !== 1'b0) begin
            fails++; $display("FAIL attacker_blocking got %0d hit %b want 100 hit 0", a_hr, a_xr);
        end
    endtask

    task automatic test_saturate_ko();
        start_fight();
        edge_lr = 10'd110; edge_rl = 10'd100; // overlap -> gap 0
        k_l = 1'b1;
        frame();
        checks++;
        if (b_hr !== 8'd2 || b_dr !== 1'b0) begin
            fails++; $display("FAIL ko_first_kick got %0d death %b want 2 death 0", b_hr, b_dr);
        end
        repeat (20) frame();
        checks++;
        if (b_hr !== 8'd2) begin fails++; $display("FAIL ko_cooldown got %0d want 2", b_hr); end
        frame();
        checks++;
        if (b_hr !== 8'd0 || b_dr !== 1'b1 || b_xr !== 1'b1) begin
            fails++; $display("FAIL ko_saturate got %0d death %b hit %b want 0 1 1", b_hr, b_dr, b_xr);
        end
        fighting = 1'b0;
        repeat (3) frame();
        checks++;
        if (b_hr !== 8'd0 || b_dr !== 1'b1) begin
            fails++; $display("FAIL ko_frozen got %0d death %b want 0 death 1", b_hr, b_dr);
        end
        fighting = 1'b1;
        @(negedge clk);
        checks++;
        if (b_hr !== 8'd12 || b_dr !== 1'b0) begin
            fails++; $display("FAIL ko_restart got %0d death %b want 12 death 0", b_hr, b_dr);
        end
    endtask

    task automatic test_double_ko();
        start_fight();
        edge_lr = 10'd100; edge_rl = 10'd100;
        k_l = 1'b1; k_r = 1'b1;
        frame();
        checks++;
        if (c_hl !== 8'd0 || c_hr !== 8'd0) begin
            fails++; $display("FAIL double_ko_health got %0d/%0d want 0/0", c_hl, c_hr);
        end
        checks++;
        if ({c_dl, c_dr, c_xl, c_xr} !== 4'b1111) begin
            fails++; $display("FAIL double_ko_flags got %b want 1111", {c_dl, c_dr, c_xl, c_xr});
        end
    endtask

    task automatic test_reset_mid_fight();
        start_fight();
        edge_lr = 10'd100; edge_rl = 10'd100;
        k_r = 1'b1;
        repeat (106) frame(); // kicks land at ticks 0,21,42,63,84,105
        checks++;
        if (a_hl !== 8'd40) begin fails++; $display("FAIL pre_reset_health got %0d want 40", a_hl); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_hl !== 8'd100) begin fails++; $display("FAIL mid_reset got %0d want 100", a_hl); end
        rst = 1'b1;
        @(negedge clk);
        frame();
        checks++;
        if (a_hl !== 8'd90 || a_xl !== 1'b1) begin
            fails++; $display("FAIL refight_after_reset got %0d hit %b want 90 hit 1", a_hl, a_xl);
        end
    endtask

    initial begin
        test_reset();
        test_punch_cooldown();
        test_reach();
        test_block();
        test_saturate_ko();
        test_double_ko();
        test_reset_mid_fight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
